mult_hilo_ctrl: RTL and testbench

//  Sequential MULT/MULTU execution unit for the MIPS datapath. It sits directly downstream of the

---
 rtl/mult_hilo_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mult_hilo_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_hilo_ctrl.sv
// mult_hilo_ctrl
//   Sequential MULT/MULTU unit that owns the architectural HI/LO registers.
//   A request accepted in IDLE latches the operand magnitudes and the result
//   sign. The unsigned product of the magnitudes then runs through a
//   LATENCY-stage registered pipeline, and the signed result is committed to
//   HI/LO. MTHI/MTLO write HI/LO directly and cancel any multiply in flight.
//   MFHI/MFLO requests are stalled while a multiply is busy.
//
//   Ports
//     clk        in   rising-edge clock
//     rst        in   synchronous active-high reset
//     start      in   multiply request, only honoured in IDLE
//     is_signed  in   1 = MULT, 0 = MULTU
//     op_a/op_b  in   multiplicand / multiplier
//     mthi/mtlo  in   write wdata into HI / LO
//     wdata      in   MTHI/MTLO data
//     mf_req     in   MFHI/MFLO pending
//     hi/lo      out  architectural HI/LO
//     busy       out  multiply in flight (CALC or COMMIT)
//     done       out  one-cycle pulse after the HI/LO commit
//     stall      out  mf_req & busy
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | waiting for start; MTHI/MTLO write directly
//   S_CALC   | product moving through the pipeline, r_cnt counts down
//   S_COMMIT | last pipeline stage valid, signed result written to HI/LO
module mult_hilo_ctrl #(
   parameter int WIDTH   = 32,
   parameter int LATENCY = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   input  logic             mf_req,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             stall
);

   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CALC   = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_mag_a;
   logic [WIDTH-1:0]   r_mag_b;
   logic               r_neg;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_done;
   logic [2*WIDTH-1:0] r_pipe [LATENCY];

   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic               w_neg;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_result;
   logic               w_mt;
   logic               w_accept;
   logic               w_commit;

   // Magnitudes stay W-bit unsigned so the most negative operand maps to
   // 2^(W-1) without overflow; only the 2W-bit product is negated.
   assign w_mag_a  = (is_signed & op_a[WIDTH-1]) ? (~op_a + ONE_W) : op_a;
   assign w_mag_b  = (is_signed & op_b[WIDTH-1]) ? (~op_b + ONE_W) : op_b;
   assign w_neg    = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
   assign w_prod   = {{WIDTH{1'b0}}, r_mag_a} * {{WIDTH{1'b0}}, r_mag_b};
   assign w_result = r_neg ? (~r_pipe[LATENCY-1] + ONE_2W) : r_pipe[LATENCY-1];
   assign w_mt     = mthi | mtlo;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Any MTHI/MTLO wins over both a new request and an in-flight multiply.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_commit    = 1'b0;
      busy        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start && !w_mt) begin
               w_accept    = 1'b1;
               w_state_nxt = S_CALC;
            end
         end
         S_CALC: begin
            busy = 1'b1;
            if (w_mt) begin
               w_state_nxt = S_IDLE;
            end else if (r_cnt == '0) begin
               w_state_nxt = S_COMMIT;
            end
         end
         S_COMMIT: begin
            busy        = 1'b1;
            w_state_nxt = S_IDLE;
            w_commit    = !w_mt;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_mag_a <= '0;
         r_mag_b <= '0;
         r_neg   <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= w_commit;
         if (w_accept) begin
            r_mag_a <= w_mag_a;
            r_mag_b <= w_mag_b;
            r_neg   <= w_neg;
            r_cnt   <= CW'(LATENCY - 1);
         end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt - CW'(1);
         end
         if (w_commit) begin
            {r_hi, r_lo} <= w_result;
         end
         if (mthi) begin
            r_hi <= wdata;
         end
         if (mtlo) begin
            r_lo <= wdata;
         end
      end
   end

   // Free-running pipeline: magnitudes are held for the whole CALC phase, so
   // the last stage is valid by COMMIT. Stale contents are never committed.
   always_ff @(posedge clk) begin
      r_pipe[0] <= w_prod;
      for (int i = 1; i < LATENCY; i++) begin
         r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign hi    = r_hi;
   assign lo    = r_lo;
   assign done  = r_done;
   assign stall = mf_req & busy;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
module tb_mult_hilo_ctrl;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        is_signed;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        mthi;
   logic        mtlo;
   logic [31:0] wdata;
   logic        mf_req;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        stall;

   int n_checks = 0;
   int n_fail   = 0;

   mult_hilo_ctrl #(.WIDTH(32), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
      .op_a(op_a), .op_b(op_b), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
      .mf_req(mf_req), .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
   );

   always #5 clk = ~clk;

   // Architectural result of MULT/MULTU as plain integer arithmetic.
   function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
      longint          sa, sb;
      longint unsigned ua, ub;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      ua = {32'd0, a};
      ub = {32'd0, b};
      return ua * ub;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one multiply and waits (bounded) for busy to fall; returns what it saw.
   task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output int nb, output logic d, output logic [31:0] h,
                         output logic [31:0] l);
      op_a = a; op_b = b; is_signed = s; start = 1'b1;
      step();
      start = 1'b0;
      nb = 0;
      while (busy === 1'b1 && nb < 20) begin
         nb++;
         step();
      end
      d = done; h = hi; l = lo;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 0; is_signed = 0; op_a = 0; op_b = 0;
      mthi = 0; mtlo = 0; wdata = 0; mf_req = 0;
      step(); step();
      rst = 1'b0;
      n_checks++;
      if ({hi, lo, busy, done, stall} !== 67'd0) begin
         n_fail++;
         $display("FAIL reset: hi=%h lo=%h busy=%b done=%b stall=%b, want all zero",
                  hi, lo, busy, done, stall);
      end
   endtask

   task automatic test_multu_max();
      int nb; logic d; logic [31:0] h, l;
      do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, nb, d, h, l);
      n_checks++;
      if (nb !== LAT + 1) begin
         n_fail++; $display("FAIL multu_max_busy: got %0d cycles, want %0d", nb, LAT + 1);
      end
      n_checks++;
      if (d !== 1'b1 || h !== 32'hFFFFFFFE || l !== 32'h00000001) begin
         n_fail++; $display("FAIL multu_max: done=%b hi=%h lo=%h, want 1 fffffffe 00000001", d, h, l);
      end
      step();
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++; $display("FAIL done_width: done=%b one cycle later, want 0", done);
      end
   endtask

   task automatic test_signed();
      int nb; logic d; logic [31:0] h, l;
      do_mul(-32'sd3, 32'd7, 1'b1, nb, d, h, l);
      n_checks++;
      if (d !== 1'b1 || h !== 32'hFFFFFFFF || l !== 32'hFFFFFFEB) begin
         n_fail++; $display("FAIL mult_m3x7: done=%b hi=%h lo=%h, want 1 ffffffff ffffffeb", d, h, l);
      end
      step();
      do_mul(-32'sd5, -32'sd6, 1'b1, nb, d, h, l);
      n_checks++;
      if (d !== 1'b1 || h !== 32'h0 || l !== 32'h1E) begin
         n_fail++; $display("FAIL mult_m5xm6: done=%b hi=%h lo=%h, want 1 00000000 0000001e", d, h, l);
      end
      step();
   endtask

   task automatic test_min_int();
      int nb; logic d; logic [31:0] h, l;
      for (int s = 1; s >= 0; s--) begin
         do_mul(32'h80000000, 32'h80000000, s[0], nb, d, h, l);
         n_checks++;
         if (d !== 1'b1 || h !== 32'h40000000 || l !== 32'h0) begin
            n_fail++;
            $display("FAIL min_int signed=%0d: done=%b hi=%h lo=%h, want 1 40000000 00000000",
                     s, d, h, l);
         end
         step();
      end
   endtask

   task automatic test_stall();
      logic [63:0] exp;
      exp = ref_prod(32'hFFFFFFF0, 32'd12345, 1'b1);
      op_a = 32'hFFFFFFF0; op_b = 32'd12345; is_signed = 1'b1; start = 1'b1; mf_req = 1'b1;
      #1;
      n_checks++;
      if (stall !== 1'b0) begin
         n_fail++; $display("FAIL stall_idle: stall=%b in start cycle, want 0", stall);
      end
      step();
      start = 1'b0;
      for (int i = 0; i < LAT + 1; i++) begin
         n_checks++;
         if (busy !== 1'b1 || stall !== 1'b1) begin
            n_fail++; $display("FAIL stall_busy[%0d]: busy=%b stall=%b, want 1 1", i, busy, stall);
         end
         step();
      end
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b1 || stall !== 1'b0 || {hi, lo} !== exp) begin
         n_fail++;
         $display("FAIL stall_done: busy=%b done=%b stall=%b hilo=%h, want 0 1 0 %h",
                  busy, done, stall, {hi, lo}, exp);
      end
      mf_req = 1'b0;
      step();
   endtask

   task automatic test_start_ignored();
      int nb;
      op_a = 32'd3; op_b = 32'd5; is_signed = 1'b0; start = 1'b1;
      step();
      op_a = 32'd100; op_b = 32'd200;
      step();
      start = 1'b0;
      nb = 2;
      while (busy === 1'b1 && nb < 20) begin
         nb++;
         step();
      end
      n_checks++;
      if (nb !== LAT + 2 || done !== 1'b1 || hi !== 32'd0 || lo !== 32'd15) begin
         n_fail++;
         $display("FAIL start_ignored: span=%0d done=%b hi=%h lo=%h, want %0d 1 0 f",
                  nb, done, hi, lo, LAT + 2);
      end
      step();
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL start_no_queue: busy=%b, want 0", busy);
      end
   endtask

   task automatic test_cancel();
      logic seen_done;
      mtlo = 1'b1; wdata = 32'hCAFEF00D;
      step();
      mtlo = 1'b0;
      n_checks++;
      if (lo !== 32'hCAFEF00D) begin
         n_fail++; $display("FAIL mtlo_idle: lo=%h, want cafef00d", lo);
      end
      op_a = 32'd7; op_b = 32'd9; is_signed = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      mthi = 1'b1; wdata = 32'h1234;
      step();
      mthi = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || hi !== 32'h1234 || lo !== 32'hCAFEF00D) begin
         n_fail++; $display("FAIL cancel_calc: busy=%b hi=%h lo=%h, want 0 1234 cafef00d", busy, hi, lo);
      end
      seen_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         seen_done |= done;
         step();
      end
      n_checks++;
      if (seen_done !== 1'b0 || hi !== 32'h1234 || lo !== 32'hCAFEF00D) begin
         n_fail++;
         $display("FAIL cancel_nocommit: done_seen=%b hi=%h lo=%h, want 0 1234 cafef00d",
                  seen_done, hi, lo);
      end
      // Cancel in the COMMIT cycle itself: only LO changes, no commit.
      op_a = 32'hFFFF; op_b = 32'hFFFF; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < LAT; i++) step();
      mtlo = 1'b1; wdata = 32'h55;
      step();
      mtlo = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h1234 || lo !== 32'h55) begin
         n_fail++;
         $display("FAIL cancel_commit: busy=%b done=%b hi=%h lo=%h, want 0 0 1234 55", busy, done, hi, lo);
      end
      step();
   endtask

   task automatic test_abort();
      logic seen;
      op_a = 32'd11; op_b = 32'd13; is_signed = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         n_fail++; $display("FAIL abort: busy=%b hi=%h lo=%h, want 0 0 0", busy, hi, lo);
      end
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         seen |= done | busy | (|lo);
         step();
      end
      n_checks++;
      if (seen !== 1'b0) begin
         n_fail++; $display("FAIL abort_quiet: activity=%b after reset, want 0", seen);
      end
   endtask

   task automatic test_mt_start_drop();
      logic seen;
      mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_0F0F;
      op_a = 32'd2; op_b = 32'd2; is_signed = 1'b0; start = 1'b1;
      step();
      mthi = 1'b0; mtlo = 1'b0; start = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || hi !== 32'hA5A5_0F0F || lo !== 32'hA5A5_0F0F) begin
         n_fail++; $display("FAIL mt_start_drop: busy=%b hi=%h lo=%h, want 0 a5a50f0f a5a50f0f", busy, hi, lo);
      end
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         seen |= busy | done;
         step();
      end
      n_checks++;
      if (seen !== 1'b0) begin
         n_fail++; $display("FAIL mt_start_quiet: busy/done seen=%b, want 0", seen);
      end
   endtask

   task automatic test_back_to_back();
      int nb; logic d; logic [31:0] h, l;
      do_mul(32'd1000, 32'd1000, 1'b0, nb, d, h, l);
      n_checks++;
      if (d !== 1'b1 || {h, l} !== 64'd1000000) begin
         n_fail++; $display("FAIL b2b_first: done=%b hilo=%h, want 1 %h", d, {h, l}, 64'd1000000);
      end
      do_mul(32'hFFFFFFFE, 32'd3, 1'b1, nb, d, h, l);
      n_checks++;
      if (nb !== LAT + 1 || d !== 1'b1 || {h, l} !== 64'hFFFFFFFF_FFFFFFFA) begin
         n_fail++;
         $display("FAIL b2b_second: busy=%0d done=%b hilo=%h, want %0d 1 fffffffffffffffa",
                  nb, d, {h, l}, LAT + 1);
      end
      step();
   endtask

   task automatic test_random();
      int nb; logic d; logic [31:0] a, b, h, l; logic s; logic [63:0] exp;
      for (int i = 0; i < 40; i++) begin
         a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0: a = 32'h80000000;
            1: b = 32'hFFFFFFFF;
            2: a = 32'd0;
            default: ;
         endcase
         exp = ref_prod(a, b, s);
         do_mul(a, b, s, nb, d, h, l);
         n_checks++;
         if (nb !== LAT + 1 || d !== 1'b1 || {h, l} !== exp) begin
            n_fail++;
            $display("FAIL random[%0d] %h*%h s=%b: busy=%0d done=%b hilo=%h, want %0d 1 %h",
                     i, a, b, s, nb, d, {h, l}, LAT + 1, exp);
         end
         if ($urandom_range(0, 1) == 1) step();
      end
      step();
   endtask

   initial begin
      test_reset();
      test_multu_max();
      test_signed();
      test_min_int();
      test_stall();
      test_start_ignored();
      test_cancel();
      test_abort();
      test_mt_start_drop();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
